dt_scan_sequencer: RTL and testbench

Raster-scan sequencer for the two-pass distance-transform engine. It walks interior pixels of the 128x128 binary image stored in the sti ROM, first in forward raster order and then in backward raster order. It issues each selected pixel to the neighbour-min kernel over a valid/ready handshake. It owns the sti ROM port and caches one 16-bit ROM word, so the ROM is read once per word rather than once per pixel.

---
 rtl/dt_pkg.sv | 33 +++
 rtl/dt_sti_word_cache.sv | 40 ++++
 rtl/dt_scan_sequencer.sv | 148 ++++++++++++++
 tb/tb_dt_scan_sequencer.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// dt_pkg: shared constants, FSM states and ROM word addressing
// for the distance-transform raster-scan sequencer.
package dt_pkg;
    localparam int unsigned IMG_W  = 128;
    localparam int unsigned IMG_H  = 128;
    localparam int unsigned STI_W  = 16;
    localparam int unsigned CRD_W  = 7;
    localparam int unsigned ADDR_W = 10;

    localparam logic [CRD_W-1:0] BND_LO = 7'd1;
    localparam logic [CRD_W-1:0] BND_HI = 7'd126;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SCAN,
        S_ISSUE,
        S_ADV,
        S_DONE
    } dt_state_e;

    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [CRD_W-1:0] row,
        input logic [CRD_W-1:0] col,
        input int unsigned      img_w,
        input int unsigned      sti_w
    );
        int unsigned a;
        a = 32'(row) * (img_w / sti_w) + 32'(col) / sti_w;
        return a[ADDR_W-1:0];
    endfunction
endpackage

// File: rtl/dt_sti_word_cache.sv
// dt_sti_word_cache: single-word sti ROM cache with hit compare
// and pixel bit select (word MSB is the leftmost pixel).
module dt_sti_word_cache
    import dt_pkg::*;
#(
    parameter int unsigned WORD_W = STI_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      inval,
    input  logic [ADDR_W-1:0]         load_addr,
    input  logic [WORD_W-1:0]         load_data,
    input  logic [ADDR_W-1:0]         cmp_addr,
    input  logic [$clog2(WORD_W)-1:0] bit_idx,
    output logic                      hit,
    output logic                      pix_bit
);
    logic [WORD_W-1:0] word_q;
    logic [ADDR_W-1:0] word_addr_q;
    logic              valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q      <= '0;
            word_addr_q <= '0;
            valid_q     <= 1'b0;
        end else if (load) begin
            word_q      <= load_data;
            word_addr_q <= load_addr;
            valid_q     <= 1'b1;
        end else if (inval) begin
            valid_q     <= 1'b0;
        end
    end

    assign hit     = valid_q && (word_addr_q == cmp_addr);
    // Column LSBs count from the MSB end of the word.
    assign pix_bit = word_q[~bit_idx];
endmodule

// File: rtl/dt_scan_sequencer.sv
// dt_scan_sequencer: forward then backward raster walk of the interior
// pixels. Define DT_SKIP_BG_EN to issue only object (bit=1) pixels.
module dt_scan_sequencer
    import dt_pkg::*;
#(
    parameter int unsigned IMG_W = dt_pkg::IMG_W,
    parameter int unsigned IMG_H = dt_pkg::IMG_H,
    parameter int unsigned STI_W = dt_pkg::STI_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              sti_rd,
    output logic [ADDR_W-1:0] sti_addr,
    input  logic [STI_W-1:0]  sti_di,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [CRD_W-1:0]  pix_row,
    output logic [CRD_W-1:0]  pix_col,
    output logic              pix_obj,
    output logic              pix_dir,
    output logic              done
);
    localparam int unsigned SEL_W = $clog2(STI_W);
    localparam logic [CRD_W-1:0] ROW_HI = CRD_W'(IMG_H - 2);
    localparam logic [CRD_W-1:0] COL_HI = CRD_W'(IMG_W - 2);
    localparam logic [CRD_W-1:0] ONE    = CRD_W'(1);

    dt_state_e        state_q, state_d;
    logic [CRD_W-1:0] row_q, col_q, row_n, col_n;
    logic             dir_q;
    logic             pass_end, load_first, load_bwd, step;
    logic             cache_hit, pix_bit, issue;
    logic [ADDR_W-1:0] cur_addr, nxt_addr;

    always_comb begin
        row_n    = row_q;
        col_n    = col_q;
        pass_end = 1'b0;
        if (!dir_q) begin
            if (col_q == COL_HI) begin
                col_n    = BND_LO;
                row_n    = row_q + ONE;
                pass_end = (row_q == ROW_HI);
            end else begin
                col_n = col_q + ONE;
            end
        end else begin
            if (col_q == BND_LO) begin
                col_n    = COL_HI;
                row_n    = row_q - ONE;
                pass_end = (row_q == BND_LO);
            end else begin
                col_n = col_q - ONE;
            end
        end
    end

    assign cur_addr = word_addr(row_q, col_q, IMG_W, STI_W);
    assign nxt_addr = word_addr(row_n, col_n, IMG_W, STI_W);

    dt_sti_word_cache #(
        .WORD_W (STI_W)
    ) u_cache (
        .clk       (clk),
        .reset     (reset),
        .load      (state_q == S_WAIT),
        .inval     (load_bwd),
        .load_addr (cur_addr),
        .load_data (sti_di),
        .cmp_addr  (nxt_addr),
        .bit_idx   (col_q[SEL_W-1:0]),
        .hit       (cache_hit),
        .pix_bit   (pix_bit)
    );

`ifdef DT_SKIP_BG_EN
    assign issue = pix_bit;
`else
    assign issue = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        load_first = 1'b0;
        load_bwd   = 1'b0;
        step       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_first = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_SCAN;
            S_SCAN:  state_d = issue ? S_ISSUE : S_ADV;
            S_ISSUE: begin
                if (pix_ready) state_d = S_ADV;
            end
            S_ADV: begin
                if (pass_end && !dir_q) begin
                    load_bwd = 1'b1;
                    state_d  = S_FETCH;
                end else if (pass_end) begin
                    state_d = S_DONE;
                end else begin
                    step    = 1'b1;
                    state_d = cache_hit ? S_SCAN : S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_first) begin
                row_q <= BND_LO;
                col_q <= BND_LO;
                dir_q <= 1'b0;
            end else if (load_bwd) begin
                row_q <= ROW_HI;
                col_q <= COL_HI;
                dir_q <= 1'b1;
            end else if (step) begin
                row_q <= row_n;
                col_q <= col_n;
            end
        end
    end

    assign sti_rd    = (state_q == S_FETCH);
    assign sti_addr  = cur_addr;
    assign pix_valid = (state_q == S_ISSUE);
    assign pix_row   = row_q;
    assign pix_col   = col_q;
    assign pix_obj   = pix_bit;
    assign pix_dir   = dir_q;
    assign done      = (state_q == S_DONE);
endmodule

// File: tb/tb_dt_scan_sequencer.sv
// tb_dt_scan_sequencer: randomized bench for the scan sequencer, checked
// against a pixel-order reference model built from the scan rules.
`timescale 1ns/1ps
module tb_dt_scan_sequencer;
    localparam int H      = 8;
    localparam int W      = 128;
    localparam int RH     = H - 2;
    localparam int BUDGET = 30000;
`ifdef DT_SKIP_BG_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        sti_rd;
    logic [9:0]  sti_addr;
    logic [15:0] sti_di;
    logic        pix_valid;
    logic        pix_ready;
    logic [6:0]  pix_row;
    logic [6:0]  pix_col;
    logic        pix_obj;
    logic        pix_dir;
    logic        done;

    dt_scan_sequencer #(
        .IMG_H (H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sti_rd    (sti_rd),
        .sti_addr  (sti_addr),
        .sti_di    (sti_di),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_row   (pix_row),
        .pix_col   (pix_col),
        .pix_obj   (pix_obj),
        .pix_dir   (pix_dir),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit          img [0:127][0:127];
    logic [15:0] rom [0:1023];
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];
    int          rd_addr_q [$];
    int          exp_rd;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;
    bit          rdy_force = 1'b1;

    always @(posedge clk) begin
        if (sti_rd) sti_di <= rom[sti_addr];
    end

    always @(negedge clk) begin
        if (sti_rd) begin
            rd_cnt <= rd_cnt + 1;
            rd_addr_q.push_back(int'(sti_addr));
        end
        if (pix_valid && pix_ready)
            obs_q.push_back({pix_dir, pix_obj, pix_row, pix_col});
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode == 1)
                pix_ready = ($urandom_range(0, 3) != 0);
            else if (rdy_mode == 0)
                pix_ready = rdy_force;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_img();
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 128; c++)
                img[r][c] = 1'b0;
    endtask

    task automatic random_img(input int pct);
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 128; c++)
                img[r][c] = ($urandom_range(0, 99) < pct);
    endtask

    // ROM word r*8+c/16 holds pixel c at bit 15-(c%16).
    task automatic build_rom();
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 128; c++)
                rom[r * (W / 16) + c / 16][15 - c % 16] = img[r][c];
    endtask

    task automatic build_expected();
        exp_q.delete();
        exp_rd = 0;
        for (int p = 0; p < 2; p++) begin
            int last;
            last = -1;
            for (int k = 0; k < RH * 126; k++) begin
                int r, c, a;
                if (p == 0) begin
                    r = 1 + k / 126;
                    c = 1 + k % 126;
                end else begin
                    r = RH - k / 126;
                    c = 126 - k % 126;
                end
                a = r * (W / 16) + c / 16;
                if (a != last) exp_rd++;
                last = a;
                if (!SKIP || img[r][c])
                    exp_q.push_back({p[0], img[r][c], r[6:0], c[6:0]});
            end
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [15:0] obs_at(input int i);
        return (i >= 0 && i < obs_q.size()) ? obs_q[i] : 16'hxxxx;
    endfunction

    function automatic logic [15:0] exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 16'hxxxx;
    endfunction

    task automatic prepare();
        build_rom();
        build_expected();
        obs_q.delete();
    endtask

    task automatic run_scan(input int mid_start, input bit start_on_done,
                            output bit ok, output bit first_rd);
        ok = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        first_rd = sti_rd;
        for (int n = 0; n < BUDGET; n++) begin
            tick();
            start = (n == mid_start);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = start_on_done && ok;
        tick();
        start = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if ({sti_rd, sti_addr} !== 11'd0) begin
            errors++;
            $display("FAIL reset_sti: got rd=%b addr=%0d want 0/0", sti_rd, sti_addr);
        end
        checks++;
        if (pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", pix_valid);
        end
        checks++;
        if ({pix_row, pix_col, pix_obj, pix_dir} !== 16'd0) begin
            errors++;
            $display("FAIL reset_pix: got row=%0d col=%0d obj=%b dir=%b want 0",
                     pix_row, pix_col, pix_obj, pix_dir);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_blank();
        bit ok, fr;
        int rd0, d0, d;
        clear_img();
        prepare();
        rd0 = rd_cnt;
        d0  = done_cnt;
        run_scan(-1, 1'b0, ok, fr);
        checks++;
        if (!ok) begin errors++; $display("FAIL blank_timeout: done=0 want 1"); end
        checks++;
        if (fr !== 1'b1) begin
            errors++;
            $display("FAIL blank_first_rd: got %b want 1", fr);
        end
        checks++;
        if (rd_cnt - rd0 != exp_rd) begin
            errors++;
            $display("FAIL blank_reads: got %0d want %0d", rd_cnt - rd0, exp_rd);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL blank_done: got %0d want 1", done_cnt - d0);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL blank_stream: at %0d got %h want %h (sizes %0d/%0d)",
                     d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_single();
        bit ok, fr;
        int a0, n41, nobj, d;
        clear_img();
        img[5][20] = 1'b1;
        prepare();
        a0 = rd_addr_q.size();
        run_scan(-1, 1'b0, ok, fr);
        n41 = 0;
        for (int i = a0; i < rd_addr_q.size(); i++)
            if (rd_addr_q[i] == 41) n41++;
        nobj = 0;
        foreach (obs_q[i]) if (obs_q[i][14]) nobj++;
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: done=0 want 1"); end
        checks++;
        if (n41 != 2) begin
            errors++;
            $display("FAIL single_addr41: got %0d fetches want 2", n41);
        end
        checks++;
        if (nobj != 2) begin
            errors++;
            $display("FAIL single_objs: got %0d want 2", nobj);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL single_stream: at %0d got %h want %h (sizes %0d/%0d)",
                     d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_stall();
        bit found, ok;
        int bad, d;
        clear_img();
        img[5][20] = 1'b1;
        prepare();
        rdy_mode  = 2;
        pix_ready = 1'b1;
        found     = 1'b0;
        ok        = 1'b0;
        bad       = 0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < BUDGET; n++) begin
            if (pix_valid && pix_row == 7'd5 && pix_col == 7'd20 && !pix_dir) begin
                pix_ready = 1'b0;
                found = 1'b1;
                break;
            end
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!pix_valid || pix_row != 7'd5 || pix_col != 7'd20 || sti_rd)
                bad++;
            tick();
        end
        pix_ready = 1'b1;
        rdy_force = 1'b1;
        rdy_mode  = 0;
        for (int n = 0; n < BUDGET; n++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) tick();
        checks++;
        if (!found) begin errors++; $display("FAIL stall_reach: target not issued"); end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_timeout: done=0 want 1"); end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL stall_stream: at %0d got %h want %h (sizes %0d/%0d)",
                     d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_border();
        bit ok, fr;
        int d0, nobj, d;
        clear_img();
        for (int i = 0; i < 128; i++) begin
            img[0][i]     = 1'b1;
            img[H - 1][i] = 1'b1;
            img[127][i]   = 1'b1;
            img[i][0]     = 1'b1;
            img[i][127]   = 1'b1;
        end
        prepare();
        d0 = done_cnt;
        run_scan(-1, 1'b0, ok, fr);
        nobj = 0;
        foreach (obs_q[i]) if (obs_q[i][14]) nobj++;
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL border_done: got %0d want 1", done_cnt - d0);
        end
        checks++;
        if (nobj != 0) begin
            errors++;
            $display("FAIL border_objs: got %0d want 0", nobj);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL border_stream: at %0d got %h want %h (sizes %0d/%0d)",
                     d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_issue();
        bit found, ok, fr;
        int d;
        random_img(50);
        prepare();
        rdy_force = 1'b0;
        rdy_mode  = 0;
        found     = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < BUDGET; n++) begin
            if (pix_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        reset = 1'b1;
        tick();
        checks++;
        if (!found) begin errors++; $display("FAIL rst_issue_reach: no pixel issued"); end
        checks++;
        if ({pix_valid, sti_rd, done} !== 3'b000) begin
            errors++;
            $display("FAIL rst_issue_out: got valid=%b rd=%b done=%b want 000",
                     pix_valid, sti_rd, done);
        end
        reset     = 1'b0;
        rdy_force = 1'b1;
        rdy_mode  = 1;
        tick();
        obs_q.delete();
        run_scan(-1, 1'b0, ok, fr);
        rdy_mode = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_rerun_timeout: done=0 want 1"); end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL rst_rerun_stream: at %0d got %h want %h (sizes %0d/%0d)",
                     d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_checker();
        bit ok, fr;
        int tog, n0, e0, d;
        clear_img();
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 128; c++)
                img[r][c] = ((r + c) % 2 == 1);
        prepare();
        rdy_force = 1'b1;
        run_scan(-1, 1'b0, ok, fr);
        tog = 0;
        for (int i = 1; i < obs_q.size(); i++)
            if (obs_q[i][15] != obs_q[i - 1][15]) tog++;
        n0 = 0;
        foreach (obs_q[i]) if (!obs_q[i][15]) n0++;
        e0 = 0;
        for (int r = 1; r <= RH; r++)
            for (int c = 1; c <= 126; c++)
                if (!SKIP || img[r][c]) e0++;
        checks++;
        if (tog != 1) begin
            errors++;
            $display("FAIL checker_dir_toggle: got %0d want 1", tog);
        end
        checks++;
        if (n0 != e0) begin
            errors++;
            $display("FAIL checker_fwd_count: got %0d want %0d", n0, e0);
        end
        checks++;
        if (obs_q.size() != 2 * e0) begin
            errors++;
            $display("FAIL checker_total: got %0d want %0d", obs_q.size(), 2 * e0);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL checker_stream: at %0d got %h want %h (sizes %0d/%0d)",
                     d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        bit ok, fr;
        int rd0, d;
        random_img($urandom_range(5, 95));
        prepare();
        rdy_mode = 1;
        rd0 = rd_cnt;
        run_scan(-1, 1'b0, ok, fr);
        rdy_mode = 0;
        checks++;
        if (rd_cnt - rd0 != exp_rd) begin
            errors++;
            $display("FAIL random_reads: got %0d want %0d", rd_cnt - rd0, exp_rd);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL random_stream: at %0d got %h want %h (sizes %0d/%0d)",
                     d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok, fr;
        int rd0, d0, d;
        random_img(30);
        prepare();
        rdy_force = 1'b1;
        rd0 = rd_cnt;
        d0  = done_cnt;
        run_scan(50, 1'b1, ok, fr);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL b2b_done: got %0d want 1", done_cnt - d0);
        end
        checks++;
        if (rd_cnt - rd0 != exp_rd) begin
            errors++;
            $display("FAIL b2b_reads: got %0d want %0d", rd_cnt - rd0, exp_rd);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL b2b_stream: at %0d got %h want %h (sizes %0d/%0d)",
                     d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_blank();
        test_single();
        test_stall();
        test_border();
        test_reset_issue();
        test_checker();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
